// File: rtl/pb_classifier.sv
// rtl/pb_classifier.sv - push-button gesture classifier (click / double click / long press / auto-repeat)
//
// Parameters:
//   LONG_CYC    hold cycles that qualify as a long press
//   DCLICK_CYC  window after release in which a second press is a double click
//   REPEAT_CYC  auto-repeat period while a long press is held
//   REPEAT_EN   1 enables rpt pulses, 0 keeps rpt low
//   CNT_W       shared counter width
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pb_down, pb_up      one-cycle edge pulses from the debouncer
//   click, dclick       registered one-cycle single / double click events
//   long_press, rpt     registered one-cycle long press / auto-repeat events
//   busy                high while a gesture is in progress
module pb_classifier #(
  parameter int LONG_CYC   = 6_000_000,
  parameter int DCLICK_CYC = 3_000_000,
  parameter int REPEAT_CYC = 1_200_000,
  parameter int REPEAT_EN  = 1,
  parameter int CNT_W      = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_down,
  input  logic pb_up,
  output logic click,
  output logic dclick,
  output logic long_press,
  output logic rpt,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    HOLD2  = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLICK_MAX = CNT_W'(DCLICK_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             RPT_ON     = (REPEAT_EN != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      click      <= 1'b0;
      dclick     <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      click      <= 1'b0;
      dclick     <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      case (state)
        IDLE: begin
          if (pb_down) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          // Release is checked first so a release on the threshold cycle stays short.
          if (pb_up) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_MAX) begin
            long_press <= 1'b1;
            state      <= LONG;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT2: begin
          // A second press on the timeout cycle still counts as a double click.
          if (pb_down) begin
            dclick <= 1'b1;
            state  <= HOLD2;
            cnt    <= '0;
          end else if (cnt == DCLICK_MAX) begin
            click <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD2: begin
          if (pb_up) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        LONG: begin
          if (pb_up) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REPEAT_MAX) begin
            rpt <= RPT_ON;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The click timeout returns the FSM to IDLE in the same edge that raises
  // click, so busy is held through the click cycle to cover the whole gesture.
  assign busy = (state != IDLE) || click;

endmodule

// File: tb/tb_pb_classifier.sv
// tb/tb_pb_classifier.sv - scoreboard bench for pb_classifier
module tb_pb_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pb_down, pb_up;
  logic a_click, a_dclick, a_long, a_rpt, a_busy;
  logic b_click, b_dclick, b_long, b_rpt, b_busy;

  pb_classifier #(
    .LONG_CYC(8), .DCLICK_CYC(5), .REPEAT_CYC(3), .REPEAT_EN(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up),
    .click(a_click), .dclick(a_dclick), .long_press(a_long), .rpt(a_rpt), .busy(a_busy)
  );

  pb_classifier #(
    .LONG_CYC(8), .DCLICK_CYC(5), .REPEAT_CYC(3), .REPEAT_EN(0), .CNT_W(4)
  ) dut_norpt (
    .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up),
    .click(b_click), .dclick(b_dclick), .long_press(b_long), .rpt(b_rpt), .busy(b_busy)
  );

  // event codes: {rpt, long_press, dclick, click}
  localparam logic [3:0] EV_CLICK  = 4'b0001;
  localparam logic [3:0] EV_DCLICK = 4'b0010;
  localparam logic [3:0] EV_LONG   = 4'b0100;
  localparam logic [3:0] EV_RPT    = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] ev;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cur_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cur_cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // dm/um: cycles carrying pb_down/pb_up, bm: cycles where busy must be high,
  // rst_at: cycle with rst_n low (-1 for none). Cycle 0 follows reset release.
  task automatic run(input logic [63:0] dm, input logic [63:0] um, input logic [63:0] bm,
                     input int rst_at, input int len);
    exp_t       e;
    logic [3:0] exp_ev;
    rst_n   = 1'b0;
    pb_down = 1'b0;
    pb_up   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) @(negedge clk);
      cur_cyc = c;
      exp_ev  = 4'b0000;
      if (sb.size() > 0 && sb[0].cyc == c) begin
        e      = sb.pop_front();
        exp_ev = e.ev;
      end
      chk("ev", {28'b0, a_rpt, a_long, a_dclick, a_click}, {28'b0, exp_ev});
      chk("ev_norpt", {28'b0, b_rpt, b_long, b_dclick, b_click}, {28'b0, exp_ev & 4'b0111});
      chk("busy", {31'b0, a_busy}, {31'b0, bm[c]});
      chk("busy_norpt", {31'b0, b_busy}, {31'b0, bm[c]});
      pb_down = dm[c];
      pb_up   = um[c];
      rst_n   = (c != rst_at);
    end
    pb_down = 1'b0;
    pb_up   = 1'b0;
    rst_n   = 1'b1;
    chk("sb_left", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // single click
    push(19, EV_CLICK);
    run(rng(10, 10), rng(13, 13), rng(11, 19), -1, 25);

    // double click
    push(17, EV_DCLICK);
    run(rng(10, 10) | rng(16, 16), rng(13, 13) | rng(20, 20), rng(11, 20), -1, 26);

    // long press with auto-repeat, release on a repeat tick
    push(19, EV_LONG);
    push(22, EV_RPT);
    push(25, EV_RPT);
    push(28, EV_RPT);
    run(rng(10, 10), rng(30, 30), rng(11, 30), -1, 35);

    // release exactly on the long threshold stays a short press
    push(24, EV_CLICK);
    run(rng(10, 10), rng(18, 18), rng(11, 24), -1, 30);

    // second press exactly on the click timeout is a double click
    push(19, EV_DCLICK);
    run(rng(10, 10) | rng(18, 18), rng(13, 13) | rng(22, 22), rng(11, 22), -1, 28);

    // reset mid-gesture drops the pending click, then a fresh click works
    push(38, EV_CLICK);
    run(rng(10, 10) | rng(30, 30), rng(13, 13) | rng(32, 32),
        rng(11, 15) | rng(31, 38), 15, 44);

    // protocol noise: pb_up in IDLE, extra pb_down in PRESS1
    push(19, EV_CLICK);
    run(rng(10, 10) | rng(12, 12), rng(5, 5) | rng(13, 13), rng(11, 19), -1, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
